apb_arbiter_2to1: RTL

APB_ARBITER_2TO1 -- requirements
Module: apb_arbiter_2to1
Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 24, APB address width.
REQ-002 SHALL have parameter DATA_WIDTH, default 16, APB data width; byte strobes are DATA_WIDTH/8 bits.
REQ-003 SHALL have parameter TIMEOUT_CYCLES, default 255, ACCESS-phase watchdog limit (used only under APB_ARB_TIMEOUT_EN).
REQ-004 SHALL have port clk, input, 1, single clock for all logic; one clock, reset is asynchronous and active-high.
REQ-005 SHALL have port rst, input, 1, asynchronous active-high reset.
REQ-006 SHALL have port reqN_psel (N=0,1), input, 1, requester N select.
REQ-007 SHALL have port reqN_penable, input, 1, requester N access phase.
REQ-008 SHALL have port reqN_pwrite, input, 1, requester N write.
REQ-009 SHALL have port reqN_paddr, input, ADDR_WIDTH, requester N address.
REQ-010 SHALL have port reqN_pwdata, input, DATA_WIDTH, requester N write data.
REQ-011 SHALL have port reqN_pstrb, input, DATA_WIDTH/8, requester N byte strobes.
REQ-012 SHALL have port reqN_pready, output, 1, completion strobe to requester N.
REQ-013 SHALL have port reqN_prdata, output, DATA_WIDTH, read data to requester N.
REQ-014 SHALL have port reqN_pslverr, output, 1, error to requester N.
REQ-015 SHALL have ports m_psel, m_penable, m_pwrite, output, 1 each, completer-side APB controls.
REQ-016 SHALL have ports m_paddr (ADDR_WIDTH), m_pwdata (DATA_WIDTH), m_pstrb (DATA_WIDTH/8), output, completer-side payload.
REQ-017 SHALL have ports m_pready (1), m_prdata (DATA_WIDTH), m_pslverr (1), input, completer response.
Function
REQ-018 SHALL implement FSM states IDLE, SETUP, ACCESS, RESP.
REQ-019 In IDLE, a requester is pending when reqN_psel=1, regardless of reqN_penable.
REQ-020 In IDLE with one requester pending, SHALL grant it; with both pending, SHALL grant the one not granted last (round-robin pointer), then go to SETUP.
REQ-021 On grant, SHALL latch the winner's pwrite/paddr/pwdata/pstrb into registers driving m_*; m_* payload SHALL remain stable until the next grant.
REQ-022 SETUP: m_psel=1, m_penable=0, one cycle, then ACCESS.
REQ-023 ACCESS: m_psel=1, m_penable=1 until m_pready=1; then RESP and m_psel/m_penable SHALL drop to 0 in the next cycle.
REQ-024 RESP (one cycle): winner's reqN_pready=1 with the prdata/pslverr registered from the m_pready cycle; then IDLE.
REQ-025 Loser's reqN_pready SHALL stay 0; its request waits, unaltered, in IDLE.
REQ-026 reqN_prdata/reqN_pslverr SHALL be 0 whenever reqN_pready=0.
REQ-027 Latency: grant-to-completer-setup 1 cycle; m_pready to requester pready 1 cycle; minimum total 4 cycles per transfer.
REQ-028 Winner's psel still high during RESP SHALL NOT be arbitrated; re-arbitration happens only in IDLE.
REQ-029 Round-robin pointer SHALL update only on grant.
Reset
REQ-030 rst=1 SHALL asynchronously force IDLE, all m_* and reqN_* outputs 0, latched payload 0, pointer = "last granted 1" (requester 0 wins first tie).
REQ-031 Reset mid-transfer SHALL abort with no pready to either requester.
Configuration
REQ-032 Macro APB_ARB_TIMEOUT_EN defined: ACCESS cycle counter; if TIMEOUT_CYCLES cycles pass without m_pready, go to RESP with pslverr=1, prdata=0, and drop m_psel.
REQ-033 Macro undefined: no counter; ACCESS waits indefinitely for m_pready.
Structure
REQ-034 Package apb_arb_pkg SHALL hold the FSM state enum and default ADDR_WIDTH/DATA_WIDTH/TIMEOUT_CYCLES constants.
REQ-035 Grant selection SHALL be sub-module rr_arbiter_2 (two request bits, pointer register, one-hot grant, advance-on-grant input).
Verification
REQ-036 Single read: req0 reads 0x000010, completer returns 0xBEEF after 2 wait states -> req0_pready one cycle, req0_prdata=0xBEEF, req1 outputs idle.
REQ-037 Simultaneous psel from both after reset -> req0 served first, req1 next; with both continuously requesting, grants alternate 0,1,0,1.
REQ-038 Write: req1 writes 0x1234 to 0x000402 with pstrb=2'b01 -> m_pwdata=0x1234, m_pstrb=2'b01, m_pwrite=1 stable through SETUP/ACCESS.
REQ-039 Completer pslverr=1 -> requester sees pslverr=1 in its pready cycle only; loser unaffected.
REQ-040 With APB_ARB_TIMEOUT_EN and TIMEOUT_CYCLES=8, m_pready held 0 -> pslverr=1, prdata=0 after 8 ACCESS cycles; without the macro, still stalled after 1000 cycles.
REQ-041 rst asserted in ACCESS -> all outputs 0 immediately; no pready; next request arbitrates from the reset pointer.

---
 rtl/apb_arb_pkg.sv | 15 +
 rtl/rr_arbiter_2.sv | 32 +++
 rtl/apb_arbiter_2to1.sv | 150 +++++++++++++++
 3 files changed

// File: rtl/apb_arb_pkg.sv
// rtl/apb_arb_pkg.sv - shared constants and FSM state type for the 2:1 APB arbiter
package apb_arb_pkg;

  localparam int APB_ARB_ADDR_WIDTH     = 24;
  localparam int APB_ARB_DATA_WIDTH     = 16;
  localparam int APB_ARB_TIMEOUT_CYCLES = 255;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2,
    RESP   = 2'd3
  } apb_arb_state_t;

endpackage

// File: rtl/rr_arbiter_2.sv
// rtl/rr_arbiter_2.sv - two-input round-robin grant with one-hot output
// The pointer holds the last winner and only moves when the caller commits a grant.
module rr_arbiter_2 (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] req,
  input  logic       advance,
  output logic [1:0] grant
);

  // 1 = requester 1 won last, so requester 0 takes the first tie after reset
  logic last_grant;

  always_comb begin
    grant = 2'b00;
    case (req)
      2'b01:   grant = 2'b01;
      2'b10:   grant = 2'b10;
      2'b11:   grant = last_grant ? 2'b01 : 2'b10;
      default: grant = 2'b00;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      last_grant <= 1'b1;
    end else if (advance && (grant != 2'b00)) begin
      last_grant <= grant[1];
    end
  end

endmodule

// File: rtl/apb_arbiter_2to1.sv
// rtl/apb_arbiter_2to1.sv - arbitrates two APB requesters onto one completer port
// Define APB_ARB_TIMEOUT_EN to add an ACCESS-phase watchdog of TIMEOUT_CYCLES cycles.
module apb_arbiter_2to1
  import apb_arb_pkg::*;
#(
  parameter int ADDR_WIDTH     = APB_ARB_ADDR_WIDTH,
  parameter int DATA_WIDTH     = APB_ARB_DATA_WIDTH,
  parameter int TIMEOUT_CYCLES = APB_ARB_TIMEOUT_CYCLES
) (
  input  logic                    clk,
  input  logic                    rst,

  input  logic                    req0_psel,
  input  logic                    req0_penable,
  input  logic                    req0_pwrite,
  input  logic [ADDR_WIDTH-1:0]   req0_paddr,
  input  logic [DATA_WIDTH-1:0]   req0_pwdata,
  input  logic [DATA_WIDTH/8-1:0] req0_pstrb,
  output logic                    req0_pready,
  output logic [DATA_WIDTH-1:0]   req0_prdata,
  output logic                    req0_pslverr,

  input  logic                    req1_psel,
  input  logic                    req1_penable,
  input  logic                    req1_pwrite,
  input  logic [ADDR_WIDTH-1:0]   req1_paddr,
  input  logic [DATA_WIDTH-1:0]   req1_pwdata,
  input  logic [DATA_WIDTH/8-1:0] req1_pstrb,
  output logic                    req1_pready,
  output logic [DATA_WIDTH-1:0]   req1_prdata,
  output logic                    req1_pslverr,

  output logic                    m_psel,
  output logic                    m_penable,
  output logic                    m_pwrite,
  output logic [ADDR_WIDTH-1:0]   m_paddr,
  output logic [DATA_WIDTH-1:0]   m_pwdata,
  output logic [DATA_WIDTH/8-1:0] m_pstrb,
  input  logic                    m_pready,
  input  logic [DATA_WIDTH-1:0]   m_prdata,
  input  logic                    m_pslverr
);

  apb_arb_state_t state, state_nxt;

  logic [1:0]            arb_grant;
  logic                  arb_advance;
  logic                  owner;
  logic [DATA_WIDTH-1:0] rsp_rdata;
  logic                  rsp_err;
  logic                  timeout_hit;

  // A requester is pending on psel alone, so penable never affects arbitration
  logic unused_penable;
  assign unused_penable = req0_penable ^ req1_penable;

  rr_arbiter_2 u_rr (
    .clk     (clk),
    .rst     (rst),
    .req     ({req1_psel, req0_psel}),
    .advance (arb_advance),
    .grant   (arb_grant)
  );

`ifdef APB_ARB_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  logic [TW-1:0] acc_cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc_cnt <= '0;
    end else if (state != ACCESS) begin
      acc_cnt <= '0;
    end else begin
      acc_cnt <= acc_cnt + 1'b1;
    end
  end

  assign timeout_hit = (state == ACCESS) && !m_pready && (acc_cnt == TW'(TIMEOUT_CYCLES - 1));
`else
  localparam int unused_timeout_cycles = TIMEOUT_CYCLES;
  assign timeout_hit = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt   = state;
    arb_advance = 1'b0;
    case (state)
      IDLE: begin
        if (arb_grant != 2'b00) begin
          arb_advance = 1'b1;
          state_nxt   = SETUP;
        end
      end
      SETUP:   state_nxt = ACCESS;
      ACCESS:  if (m_pready || timeout_hit) state_nxt = RESP;
      RESP:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Payload is captured only at grant so the completer sees it stable for the whole transfer
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      owner    <= 1'b0;
      m_pwrite <= 1'b0;
      m_paddr  <= '0;
      m_pwdata <= '0;
      m_pstrb  <= '0;
    end else if (arb_advance) begin
      owner    <= arb_grant[1];
      m_pwrite <= arb_grant[1] ? req1_pwrite : req0_pwrite;
      m_paddr  <= arb_grant[1] ? req1_paddr  : req0_paddr;
      m_pwdata <= arb_grant[1] ? req1_pwdata : req0_pwdata;
      m_pstrb  <= arb_grant[1] ? req1_pstrb  : req0_pstrb;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rsp_rdata <= '0;
      rsp_err   <= 1'b0;
    end else if (state == ACCESS && m_pready) begin
      rsp_rdata <= m_prdata;
      rsp_err   <= m_pslverr;
    end else if (timeout_hit) begin
      rsp_rdata <= '0;
      rsp_err   <= 1'b1;
    end
  end

  assign m_psel    = (state == SETUP) || (state == ACCESS);
  assign m_penable = (state == ACCESS);

  assign req0_pready  = (state == RESP) && !owner;
  assign req1_pready  = (state == RESP) && owner;
  assign req0_prdata  = req0_pready ? rsp_rdata : '0;
  assign req1_prdata  = req1_pready ? rsp_rdata : '0;
  assign req0_pslverr = req0_pready & rsp_err;
  assign req1_pslverr = req1_pready & rsp_err;

endmodule
